bidir_queue: RTL and testbench
==============================

// Module: bidir_queue
// PURPOSE
//  Synchronous FIFO with one shared bidirectional 8-bit data bus (io).
//  rw selects direction: rw=0 means the host drives io and the queue pushes it;
//  rw=1 means the queue drives io and pops. en qualifies every operation.
//  Standalone buffer between a byte-wide bus master and a consumer.
// PARAMETERS
//  DATA_W  8     width of io and of each storage word
//  DEPTH   1024  number of entries; must be a power of 2
//  ADDR_W  10    $clog2(DEPTH); pointer width (localparam)
// PORTS
//  clk      in     1       single clock; all state updates on the rising edge
//  reset_n  in     1       asynchronous, active-low reset
//  en       in     1       1: operation enabled this cycle; 0: hold all state, io=Z
//  rw       in     1       0: write (push from io); 1: read (pop onto io)
//  io       inout  DATA_W  shared data bus; driven by the queue only when en&rw
//  empty    out    1       1 when count==0
//  full     out    1       1 when count==DEPTH
//  err      out    1       only with QUEUE_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - State: mem[DEPTH], wr_ptr and rd_ptr (ADDR_W bits each, wrap modulo DEPTH),
//    count (ADDR_W+1 bits), dout register (DATA_W bits).
//  - Reset (async, reset_n=0): wr_ptr=rd_ptr=0, count=0, dout=0, empty=1, full=0.
//    mem contents are not reset. An operation in progress is abandoned.
//  - Push: at the rising edge with en=1, rw=0, !full: mem[wr_ptr]<=io,
//    wr_ptr++, count++.
//  - Pop: at the rising edge with en=1, rw=1, !empty: dout<=mem[rd_ptr],
//    rd_ptr++, count--. Latency is 1 clock: popped data is on io after the edge.
//  - io tristate: io = (en && rw) ? dout : 'z (combinational on en and rw).
//  - Push when full is ignored; no state changes. Pop when empty is ignored;
//    dout holds its last value.
//  - Push and pop cannot occur in the same cycle because rw is a single bit.
//  - en=0: no state changes, io=Z, flags hold.
//  - empty and full are combinational decodes of count. Both update in the
//    cycle after the edge that changes count.
//  - Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering is strict FIFO.
// CONFIGURATION
//  QUEUE_ERR_EN defined: adds output port err.
//    - err is a sticky bit, set at the edge of a push-when-full or a
//      pop-when-empty (with en=1).
//    - err is cleared only by reset; its reset value is 0.
//  QUEUE_ERR_EN undefined: no err port and no error logic. Overflow and
//    underflow are silently ignored as described above.
// STRUCTURE
//  - Package queue_pkg: DATA_W/DEPTH defaults, the ADDR_W computation, and
//    an op enum {OP_IDLE, OP_PUSH, OP_POP} decoded from en/rw.
//  - Sub-module queue_mem: simple dual-port RAM with a synchronous write port
//    and a synchronous read port, DEPTH x DATA_W.
//  - The top level holds pointers, count, flags, dout and the io tristate.
// TESTING
//  1. Reset with reset_n=0 and en=1, rw=1 -> empty=1, full=0, io=0x00 (dout
//     reset); release reset.
//  2. Push 0x01..0x05 (rw=0, en=1, one per clock), then pop 5 -> io shows
//     0x01..0x05 in order, one clock after each pop edge; empty=1 after the
//     5th pop.
//  3. Push DEPTH=1024 values (i & 0xFF) -> full=1 after the 1024th edge.
//     Push 0xAA -> ignored. Pop 1024 -> data 0x00,0x01,...,0xFF repeating;
//     the first popped value is 0x00 (not 0xAA).
//  4. en=0 for 4 clocks with rw toggling -> io=Z, count/flags unchanged.
//  5. Pop on empty -> io holds the last value, empty stays 1. With
//     QUEUE_ERR_EN, err=1 and remains 1 until reset.
//  6. Assert reset_n=0 mid-stream (after 10 pushes) -> empty=1 immediately
//     (async). A subsequent push/pop of 0x3C returns 0x3C.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and defaults for the bidirectional-bus queue.
// The optional QUEUE_ERR_EN macro is consumed by bidir_queue, not by this package.
package queue_pkg;

  localparam int unsigned QUEUE_DATA_W = 8;
  localparam int unsigned QUEUE_DEPTH  = 1024;

  // Pointer width for a given depth; a depth of 1 still needs one address bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned QUEUE_ADDR_W = addr_width(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_e;

  // en gates everything; rw then picks the direction of the shared bus.
  function automatic op_e decode_op(input logic en, input logic rw);
    op_e op;
    if (!en) begin
      op = OP_IDLE;
    end else if (rw) begin
      op = OP_POP;
    end else begin
      op = OP_PUSH;
    end
    return op;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// Simple dual-port DEPTH x DATA_W RAM: synchronous write port, synchronous read port.
// The read register is reset and holds its value when no read is requested.
module queue_mem
  import queue_pkg::*;
#(
  parameter int unsigned DATA_W = QUEUE_DATA_W,
  parameter int unsigned DEPTH  = QUEUE_DEPTH,
  parameter int unsigned ADDR_W = QUEUE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bidir_queue.sv
// FIFO behind a single shared bidirectional byte bus: rw=0 pushes io, rw=1 pops onto io.
// Define QUEUE_ERR_EN to add the sticky overflow/underflow flag on port err.
module bidir_queue
  import queue_pkg::*;
#(
  parameter int unsigned DATA_W = QUEUE_DATA_W,
  parameter int unsigned DEPTH  = QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              rw,
  inout  wire  [DATA_W-1:0] io,
  output logic              empty,
  output logic              full
`ifdef QUEUE_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned     ADDR_W     = addr_width(DEPTH);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  op_e               op;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout;

  assign op    = decode_op(en, rw);
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // Overflow and underflow requests are dropped here, so nothing downstream sees them.
  assign push = (op == OP_PUSH) && !full;
  assign pop  = (op == OP_POP) && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The RAM read register is the queue's dout: reset to zero, updated only on pop.
  queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (io),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (dout)
  );

  assign io = (en && rw) ? dout : {DATA_W{1'bz}};

`ifdef QUEUE_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (((op == OP_PUSH) && full) || ((op == OP_POP) && empty)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_bidir_queue.sv
// Self-checking bench for bidir_queue: directed vector table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_bidir_queue;
  import queue_pkg::*;

  localparam int unsigned DEPTH = QUEUE_DEPTH;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       rw = 1'b0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_data = 8'h00;
  wire  [7:0] io;
  logic       empty;
  logic       full;
`ifdef QUEUE_ERR_EN
  logic       err;
`endif

  assign io = tb_oe ? tb_data : 8'bz;

  always #5 clk = ~clk;

  bidir_queue dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .rw      (rw),
    .io      (io),
    .empty   (empty),
    .full    (full)
`ifdef QUEUE_ERR_EN
    ,
    .err     (err)
`endif
  );

  // Reference model
  logic [7:0] model_q[$];
  logic [7:0] model_dout;
  logic       model_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       rw;
    logic [7:0] data;
    logic       exp_empty;
    logic       exp_full;
    logic       chk_io;
    logic [7:0] exp_io;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_dout = 8'h00;
    model_err  = 1'b0;
  endtask

  task automatic model_edge();
    if (en) begin
      if (!rw) begin
        if (model_q.size() < DEPTH) model_q.push_back(tb_data);
        else model_err = 1'b1;
      end else begin
        if (model_q.size() > 0) model_dout = model_q.pop_front();
        else model_err = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic e, input logic r, input logic [7:0] d);
    en      = e;
    rw      = r;
    tb_data = d;
    tb_oe   = !(e && r);
  endtask

  // One clock: model follows the same edge, outputs sampled 1ns after it.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".empty"}, {31'b0, empty}, {31'b0, model_q.size() == 0});
    check({tag, ".full"}, {31'b0, full}, {31'b0, model_q.size() == DEPTH});
    if (en && rw) check({tag, ".io"}, {24'b0, io}, {24'b0, model_dout});
`ifdef QUEUE_ERR_EN
    check({tag, ".err"}, {31'b0, err}, {31'b0, model_err});
`endif
  endtask

  task automatic add_vec(input logic e, input logic r, input logic [7:0] d, input logic ee,
                         input logic ef, input logic ci, input logic [7:0] ei);
    vec_t v;
    v.en = e; v.rw = r; v.data = d; v.exp_empty = ee; v.exp_full = ef;
    v.chk_io = ci; v.exp_io = ei;
    vecs.push_back(v);
  endtask

  initial begin
    // 1. Reset with a pop requested: bus shows the reset dout.
    model_reset();
    drive(1'b1, 1'b1, 8'h00);
    #2;
    check("reset.empty", {31'b0, empty}, 32'd1);
    check("reset.full", {31'b0, full}, 32'd0);
    check("reset.io", {24'b0, io}, 32'h00);
    @(posedge clk);
    #1;
    check("reset.hold_empty", {31'b0, empty}, 32'd1);
`ifdef QUEUE_ERR_EN
    check("reset.err", {31'b0, err}, 32'd0);
`endif
    drive(1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 2. Directed table: push 1..5, pop 5, underflow, bus release while idle.
    for (int i = 1; i <= 5; i++) add_vec(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) add_vec(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'(i));
    add_vec(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05);
    add_vec(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05);
    add_vec(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    add_vec(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05);
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].rw, vecs[i].data);
      step();
      check("tbl.empty", {31'b0, empty}, {31'b0, vecs[i].exp_empty});
      check("tbl.full", {31'b0, full}, {31'b0, vecs[i].exp_full});
      if (vecs[i].chk_io) check("tbl.io", {24'b0, io}, {24'b0, vecs[i].exp_io});
    end
`ifdef QUEUE_ERR_EN
    check("tbl.err_after_underflow", {31'b0, err}, 32'd1);
`endif

    // 3. Fill to DEPTH, overflow push ignored, drain in order with wrap.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'(i & 8'hFF));
      step();
      if (i == DEPTH - 2) check("fill.not_full_yet", {31'b0, full}, 32'd0);
    end
    check("fill.full", {31'b0, full}, 32'd1);
    check("fill.not_empty", {31'b0, empty}, 32'd0);
    drive(1'b1, 1'b0, 8'hAA);
    step();
    check("overflow.full", {31'b0, full}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 8'h00);
      step();
      check("drain.io", {24'b0, io}, {24'b0, 8'(i & 8'hFF)});
      if (i == 0) check("drain.not_full", {31'b0, full}, 32'd0);
    end
    check("drain.empty", {31'b0, empty}, 32'd1);

    // 4. Idle with rw toggling: bus released, state frozen.
    foreach (model_q[i]) model_q.delete();
    drive(1'b1, 1'b0, 8'h11); step();
    drive(1'b1, 1'b0, 8'h22); step();
    drive(1'b1, 1'b0, 8'h33); step();
    drive(1'b1, 1'b1, 8'h00); step();
    check("idle.pre_io", {24'b0, io}, 32'h11);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'(i % 2), 8'h00);
      step();
      check("idle.io_released", {24'b0, io}, 32'h00);
      check_model("idle");
    end
    drive(1'b1, 1'b1, 8'h00); step();
    check("idle.next_pop", {24'b0, io}, 32'h22);

    // 5. Drain, then pop on empty: dout held.
    drive(1'b1, 1'b1, 8'h00); step();
    check("under.last", {24'b0, io}, 32'h33);
    for (int i = 0; i < 3; i++) begin
      step();
      check("under.hold_io", {24'b0, io}, 32'h33);
      check_model("under");
    end
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step();
      check_model("under.sticky");
    end

    // 6. Async reset mid-stream.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i));
      step();
    end
    check("mid.not_empty", {31'b0, empty}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid.async_empty", {31'b0, empty}, 32'd1);
    check_model("mid.reset");
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 8'h3C); step();
    drive(1'b1, 1'b1, 8'h00); step();
    check("mid.roundtrip", {24'b0, io}, 32'h3C);
    check_model("mid.after");

    // Randomized traffic in phases with varying pop bias.
    for (int ph = 0; ph < 4; ph++) begin
      int unsigned pop_pct;
      pop_pct = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 80 : 35;
      for (int i = 0; i < 600; i++) begin
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 99) < pop_pct, 8'($urandom));
        step();
        check_model("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
